ddc_cic_decim: RTL and testbench

DDC_CIC_DECIM -- requirements
Module: ddc_cic_decim

---
 rtl/ddc_cic_decim.sv | 154 +++++++++++++++
 tb/tb_ddc_cic_decim.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_cic_decim.sv
// rtl/ddc_cic_decim.sv - three-stage CIC decimator (R = 4..64) with pipelined combs and gain-normalised output
module ddc_cic_decim #(
  parameter int INBITWIDTH  = 32,
  parameter int STAGES      = 3,
  parameter int ACCBITWIDTH = INBITWIDTH + 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [INBITWIDTH-1:0] din,
  input  logic                         din_valid,
  input  logic [2:0]                   dec_log2,
  output logic signed [INBITWIDTH-1:0] dout,
  output logic                         dout_valid
);

  localparam int AW = ACCBITWIDTH;

  logic [2:0]                   cfg_q, cfg_d;
  logic [5:0]                   cnt_q, cnt_d;
  logic [5:0]                   last_cnt;
  logic [4:0]                   shamt;
  logic                         capture;
  logic signed [AW-1:0]         x_ext;

  logic signed [AW-1:0]         i1_q, i1_d;
  logic signed [AW-1:0]         i2_q, i2_d;
  logic signed [AW-1:0]         i3_q, i3_d;

  logic signed [AW-1:0]         d_q, d_d;
  logic signed [AW-1:0]         d_prev_q, d_prev_d;
  logic signed [AW-1:0]         c1_q, c1_d;
  logic signed [AW-1:0]         c1_prev_q, c1_prev_d;
  logic signed [AW-1:0]         c2_q, c2_d;
  logic signed [AW-1:0]         c2_prev_q, c2_prev_d;
  logic signed [AW-1:0]         c3_q, c3_d;

  logic                         tok0_q, tok0_d;
  logic                         tok1_q, tok1_d;
  logic                         tok2_q, tok2_d;
  logic                         tok3_q, tok3_d;

  logic signed [INBITWIDTH-1:0] dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;

  // Out-of-range ratios collapse to R=4 at load time so the datapath only ever sees 2..6.
  always_comb begin
    cfg_d = dec_log2;
    if (dec_log2 < 3'd2 || dec_log2 == 3'd7) begin
      cfg_d = 3'd2;
    end
  end

  always_comb begin
    last_cnt = ~(6'h3f << cfg_q);
    shamt    = 5'(cfg_q) * 5'(STAGES);
    capture  = din_valid && (cnt_q == last_cnt);
    x_ext    = AW'(din);
  end

  // Integrators and decimation counter advance only on accepted inputs.
  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    i3_d  = i3_q;
    cnt_d = cnt_q;
    if (din_valid) begin
      i1_d  = i1_q + x_ext;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = (cnt_q == last_cnt) ? 6'd0 : cnt_q + 6'd1;
    end
  end

  // Each comb stage and its delay element move only when a token sits in the stage feeding it.
  always_comb begin
    d_d          = d_q;
    d_prev_d     = d_prev_q;
    c1_d         = c1_q;
    c1_prev_d    = c1_prev_q;
    c2_d         = c2_q;
    c2_prev_d    = c2_prev_q;
    c3_d         = c3_q;
    dout_d       = dout_q;
    tok0_d       = capture;
    tok1_d       = tok0_q;
    tok2_d       = tok1_q;
    tok3_d       = tok2_q;
    dout_valid_d = tok3_q;

    if (capture) begin
      d_d = i3_q;
    end
    if (tok0_q) begin
      c1_d     = d_q - d_prev_q;
      d_prev_d = d_q;
    end
    if (tok1_q) begin
      c2_d      = c1_q - c1_prev_q;
      c1_prev_d = c1_q;
    end
    if (tok2_q) begin
      c3_d      = c2_q - c2_prev_q;
      c2_prev_d = c2_q;
    end
    if (tok3_q) begin
      dout_d = INBITWIDTH'(c3_q >>> shamt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_q        <= cfg_d;
      cnt_q        <= '0;
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      d_q          <= '0;
      d_prev_q     <= '0;
      c1_q         <= '0;
      c1_prev_q    <= '0;
      c2_q         <= '0;
      c2_prev_q    <= '0;
      c3_q         <= '0;
      tok0_q       <= 1'b0;
      tok1_q       <= 1'b0;
      tok2_q       <= 1'b0;
      tok3_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      d_q          <= d_d;
      d_prev_q     <= d_prev_d;
      c1_q         <= c1_d;
      c1_prev_q    <= c1_prev_d;
      c2_q         <= c2_d;
      c2_prev_q    <= c2_prev_d;
      c3_q         <= c3_d;
      tok0_q       <= tok0_d;
      tok1_q       <= tok1_d;
      tok2_q       <= tok2_d;
      tok3_q       <= tok3_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ddc_cic_decim.sv
// tb/tb_ddc_cic_decim.sv - bench for ddc_cic_decim: vector table, random traffic and reset corner sequences
module tb_ddc_cic_decim;

  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic signed [W-1:0] din = '0;
  logic                din_valid = 1'b0;
  logic [2:0]          dec_log2 = 3'd2;
  logic signed [W-1:0] dout;
  logic                dout_valid;

  always #5 clk = ~clk;

  ddc_cic_decim #(.INBITWIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .dec_log2  (dec_log2),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  longint xs[$];
  int     xcyc[$];
  int     bl2 = 2;
  int     nstrobe = 0;
  int     last_sc = 0;
  int     prev_sc = 0;
  longint held = 0;
  bit     rst_edge = 1'b0;

  typedef struct {
    logic [2:0] dec;
    int         din_v;
    int         period;
    int         n_in;
    int         exp_dout;
    int         exp_space;
    int         exp_strobes;
  } vec_t;

  vec_t vecs[7];

  function automatic int map_log2(logic [2:0] d);
    return (d < 3'd2 || d == 3'd7) ? 2 : int'(d);
  endfunction

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Decimated output j is the R-wide boxcar cubed, applied to the accepted-input stream.
  function automatic longint cic_ref(int j);
    int     r = 1 << bl2;
    int     m = j * r + r - 1;
    longint h2[0:127];
    longint h[0:191];
    longint y = 0;
    for (int k = 0; k < 128; k++) h2[k] = 0;
    for (int k = 0; k < 192; k++) h[k] = 0;
    for (int a = 0; a < r; a++)
      for (int b = 0; b < r; b++)
        h2[a + b]++;
    for (int k = 0; k <= 3 * r - 3; k++)
      for (int c = 0; c < r; c++)
        if (k - c >= 0 && k - c <= 2 * r - 2) h[k] += h2[k - c];
    for (int k = 0; k <= 3 * r - 3; k++) begin
      int i;
      i = m - 3 - k;
      if (i >= 0 && i < xs.size()) y += h[k] * xs[i];
    end
    return y;
  endfunction

  function automatic logic signed [W-1:0] exp_dout(int j);
    longint y;
    y = cic_ref(j);
    return 32'(y >>> (3 * bl2));
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      bl2 = map_log2(dec_log2);
      xs.delete();
      xcyc.delete();
      nstrobe = 0;
      held = 0;
      last_sc = 0;
      prev_sc = 0;
      rst_edge = 1'b1;
    end else begin
      rst_edge = 1'b0;
      if (din_valid) begin
        xs.push_back(longint'(din));
        xcyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    int r;
    int idx;
    bit due;
    r = 1 << bl2;
    if (rst_edge) begin
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
    end else begin
      idx = nstrobe * r + r - 1;
      due = 1'b0;
      if (idx < xs.size()) begin
        if (xcyc[idx] + 4 == cyc) due = 1'b1;
      end
      if (due || dout_valid) begin
        check("strobe_timing", dout_valid, due);
        if (due && dout_valid) check("dout_value", dout, exp_dout(nstrobe));
        if (due) nstrobe++;
        if (dout_valid) begin
          prev_sc = last_sc;
          last_sc = cyc;
          held = dout;
        end
      end else begin
        check("dout_hold", dout, held);
      end
    end
  end

  task automatic apply_reset(int n, logic [2:0] d);
    rst = 1'b0;
    dec_log2 = d;
    din_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic feed(int n, int v, int period);
    for (int k = 0; k < n; k++) begin
      din = v;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      repeat (period - 1) @(negedge clk);
    end
    din_valid = 1'b0;
  endtask

  task automatic drain(int n);
    din_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{3'd2, 1000, 1, 40, 1000, 4, 10};
    vecs[1] = '{3'd6, -5000, 1, 320, -5000, 64, 5};
    vecs[2] = '{3'd2, 1000, 2, 40, 1000, 8, 10};
    vecs[3] = '{3'd6, -2147483647 - 1, 1, 2000, -2147483647 - 1, 64, 31};
    vecs[4] = '{3'd7, 777, 1, 24, 777, 4, 6};
    vecs[5] = '{3'd0, -3, 1, 24, -3, 4, 6};
    vecs[6] = '{3'd4, 123456, 3, 64, 123456, 48, 4};

    // Reset held with live input, then the first cycle after release.
    rst = 1'b0;
    din = 12345;
    din_valid = 1'b1;
    dec_log2 = 3'd2;
    repeat (3) begin
      @(negedge clk);
      check("reset_dout", dout, 0);
      check("reset_valid", dout_valid, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("release_dout", dout, 0);
    check("release_valid", dout_valid, 0);
    drain(4);

    for (int v = 0; v < 7; v++) begin
      apply_reset(2, vecs[v].dec);
      feed(vecs[v].n_in, vecs[v].din_v, vecs[v].period);
      drain(8);
      check($sformatf("vec%0d_strobes", v), nstrobe, vecs[v].exp_strobes);
      check($sformatf("vec%0d_steady", v), dout, vecs[v].exp_dout);
      check($sformatf("vec%0d_spacing", v), last_sc - prev_sc, vecs[v].exp_space);
    end

    for (int rnd = 0; rnd < 6; rnd++) begin
      apply_reset(2, 3'($urandom_range(0, 7)));
      for (int k = 0; k < 300; k++) begin
        din = $urandom;
        din_valid = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
      drain(8);
      check($sformatf("rand%0d_count", rnd), nstrobe, xs.size() / (1 << bl2));
    end

    // Reset pulse while a token is in flight, then a ratio change that must wait for the next reset.
    apply_reset(2, 3'd2);
    feed(10, 500, 1);
    check("pre_pulse_dout", dout, 7);
    rst = 1'b0;
    @(negedge clk);
    check("pulse_dout", dout, 0);
    check("pulse_valid", dout_valid, 0);
    rst = 1'b1;
    dec_log2 = 3'd3;
    feed(8, 500, 1);
    drain(8);
    check("r_stays_4", nstrobe, 2);
    apply_reset(2, 3'd3);
    feed(12, 500, 1);
    drain(8);
    check("r_now_8", nstrobe, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
